// File: rtl/priority_grant_decoder_if.sv
// Request/grant bundle between the request encoder, the grant decoder and the shared resource.
// master drives the encoded request and done; slave is the grant decoder.
interface priority_grant_decoder_if #(
   parameter int CNT_W = 8
);
   logic             A;
   logic             B;
   logic             V;
   logic             done;
   logic             G3;
   logic             G2;
   logic             G1;
   logic             G0;
   logic             busy;
   logic [1:0]       code_q;
   logic [CNT_W-1:0] grant_count;
   logic             timeout;

   modport master (
      output A, B, V, done,
      input  G3, G2, G1, G0, busy, code_q, grant_count, timeout
   );

   modport slave (
      input  A, B, V, done,
      output G3, G2, G1, G0, busy, code_q, grant_count, timeout
   );
endinterface

// File: rtl/priority_grant_decoder.sv
// Decodes the encoded {A,B,V} request into a held, registered one-hot grant with a one-cycle release gap.
// Optional forced release after TIMEOUT_CYCLES grant cycles when GRANT_TIMEOUT_EN is defined.
//
// state     | meaning
// S_IDLE    | no grant; accepts the next valid request
// S_GRANT   | one G bit held until done (or timeout)
// S_RELEASE | one-cycle gap, busy high, no grant
module priority_grant_decoder #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int          CNT_W          = 8
) (
   input logic                      clk,
   input logic                      rst,
   priority_grant_decoder_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       grant_q, grant_d;
   logic             busy_q, busy_d;
   logic [1:0]       code_q, code_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
   logic             to_hit;

`ifdef GRANT_TIMEOUT_EN
   localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] tmr_q, tmr_d;

   // Loaded on grant entry, terminal count after TIMEOUT_CYCLES grant cycles.
   assign to_hit = (state_q == S_GRANT) && (tmr_q == 8'd0);

   always_comb begin
      tmr_d = tmr_q;
      if (state_q == S_IDLE && bus.V) begin
         tmr_d = TMR_LOAD;
      end else if (state_q == S_GRANT && tmr_q != 8'd0) begin
         tmr_d = tmr_q - 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmr_q <= 8'd0;
      end else begin
         tmr_q <= tmr_d;
      end
   end
`else
   logic [7:0] unused_timeout_cfg;

   assign to_hit             = 1'b0;
   assign unused_timeout_cfg = 8'(TIMEOUT_CYCLES);
`endif

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      busy_d    = busy_q;
      code_d    = code_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            grant_d = 4'b0000;
            busy_d  = 1'b0;
            if (bus.V) begin
               state_d = S_GRANT;
               // Code 00 is requester 3, so the grant bit walks down from bit 3.
               grant_d = 4'b1000 >> {bus.A, bus.B};
               busy_d  = 1'b1;
               code_d  = {bus.A, bus.B};
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         S_GRANT: begin
            if (bus.done) begin
               state_d = S_RELEASE;
               grant_d = 4'b0000;
               busy_d  = 1'b1;
            end else if (to_hit) begin
               state_d   = S_RELEASE;
               grant_d   = 4'b0000;
               busy_d    = 1'b1;
               timeout_d = 1'b1;
            end
         end
         S_RELEASE: begin
            state_d = S_IDLE;
            grant_d = 4'b0000;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = 4'b0000;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         grant_q   <= 4'b0000;
         busy_q    <= 1'b0;
         code_q    <= 2'b00;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         busy_q    <= busy_d;
         code_q    <= code_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.G3          = grant_q[3];
   assign bus.G2          = grant_q[2];
   assign bus.G1          = grant_q[1];
   assign bus.G0          = grant_q[0];
   assign bus.busy        = busy_q;
   assign bus.code_q      = code_q;
   assign bus.grant_count = cnt_q;
   assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_priority_grant_decoder.sv
// Bench for priority_grant_decoder: directed steps plus random traffic against a behavioural model.
module tb_priority_grant_decoder;

   localparam int CNT_W = 8;
   localparam int TO    = 4;
`ifdef GRANT_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   // Model: which requester holds the grant (-1 none), release gap flag, cycles spent in grant.
   int       m_owner;
   bit       m_rel;
   int       m_tmr;
   bit       m_to;
   bit [1:0] m_code;
   int       m_count;

   priority_grant_decoder_if #(.CNT_W(CNT_W)) bus ();

   priority_grant_decoder #(
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_owner = -1;
      m_rel   = 1'b0;
      m_tmr   = 0;
      m_to    = 1'b0;
      m_code  = 2'b00;
      m_count = 0;
   endtask

   task automatic model_step(input bit a, input bit b, input bit v, input bit d);
      m_to = 1'b0;
      if (m_rel) begin
         m_rel = 1'b0;
      end else if (m_owner >= 0) begin
         m_tmr = m_tmr + 1;
         if (d) begin
            m_owner = -1;
            m_rel   = 1'b1;
         end else if (TO_EN && m_tmr == TO) begin
            m_owner = -1;
            m_rel   = 1'b1;
            m_to    = 1'b1;
         end
      end else if (v) begin
         m_code  = {a, b};
         m_owner = 3 - int'({a, b});
         m_count = (m_count + 1) % (1 << CNT_W);
         m_tmr   = 0;
      end
   endtask

   task automatic check(input string tag);
      logic [3:0] g_obs;
      logic [3:0] g_exp;
      logic       busy_exp;
      g_obs    = {bus.G3, bus.G2, bus.G1, bus.G0};
      g_exp    = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      busy_exp = (m_owner >= 0) || m_rel;
      checks++;
      assert (g_obs === g_exp) else begin
         failures++;
         $error("FAIL %s grant observed=%b expected=%b", tag, g_obs, g_exp);
      end
      checks++;
      assert (bus.busy === busy_exp) else begin
         failures++;
         $error("FAIL %s busy observed=%b expected=%b", tag, bus.busy, busy_exp);
      end
      checks++;
      assert (bus.code_q === m_code) else begin
         failures++;
         $error("FAIL %s code_q observed=%b expected=%b", tag, bus.code_q, m_code);
      end
      checks++;
      assert (bus.grant_count === CNT_W'(m_count)) else begin
         failures++;
         $error("FAIL %s grant_count observed=%0d expected=%0d", tag, bus.grant_count, m_count);
      end
      checks++;
      assert (bus.timeout === m_to) else begin
         failures++;
         $error("FAIL %s timeout observed=%b expected=%b", tag, bus.timeout, m_to);
      end
   endtask

   task automatic cyc(input bit a, input bit b, input bit v, input bit d, input string tag);
      bus.A    = a;
      bus.B    = b;
      bus.V    = v;
      bus.done = d;
      @(posedge clk);
      model_step(a, b, v, d);
      #1;
      check(tag);
   endtask

   task automatic do_reset();
      bus.A    = 1'b0;
      bus.B    = 1'b0;
      bus.V    = 1'b0;
      bus.done = 1'b0;
      rst      = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      check("reset");
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      model_reset();
      do_reset();

      // First grant on code 10, done at edge 4.
      cyc(1'b1, 1'b0, 1'b1, 1'b0, "g1_accept");
      checks++;
      assert (bus.G1 === 1'b1) else begin
         failures++;
         $error("FAIL g1_direct observed=%b expected=1", bus.G1);
      end
      cyc(1'b0, 1'b1, 1'b0, 1'b0, "g1_hold2");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, "g1_hold3");
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "g1_done");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, "g1_idle");

      // All four codes, each followed by done.
      for (int c = 0; c < 4; c++) begin
         cyc(c[1], c[0], 1'b1, 1'b0, "sweep_grant");
         cyc(1'b0, 1'b0, 1'b0, 1'b0, "sweep_hold");
         cyc(1'b0, 1'b0, 1'b0, 1'b1, "sweep_done");
         cyc(1'b0, 1'b0, 1'b0, 1'b0, "sweep_rel");
      end

      // No preemption by a higher-priority code; held V wins two edges after done.
      cyc(1'b1, 1'b1, 1'b1, 1'b0, "nopre_grant");
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, "nopre_hold");
      cyc(1'b0, 1'b0, 1'b1, 1'b1, "nopre_done");
      cyc(1'b0, 1'b0, 1'b1, 1'b0, "nopre_rel");
      cyc(1'b0, 1'b0, 1'b1, 1'b0, "nopre_next");
      checks++;
      assert (bus.G3 === 1'b1) else begin
         failures++;
         $error("FAIL b2b_g3 observed=%b expected=1", bus.G3);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "nopre_done2");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, "nopre_idle");

      // Asynchronous reset between edges during a grant.
      cyc(1'b0, 1'b1, 1'b1, 1'b0, "arst_grant");
      @(negedge clk);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("async_rst");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("async_rel");

      // Long hold without done (forced release only with the timeout build).
      cyc(1'b0, 1'b1, 1'b1, 1'b0, "hold_grant");
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, "hold_cyc");
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "hold_done");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, "hold_idle");

`ifdef GRANT_TIMEOUT_EN
      // Forced release after TO grant cycles, then done coinciding with the limit.
      cyc(1'b1, 1'b0, 1'b1, 1'b0, "to_grant");
      for (int i = 0; i < TO - 1; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, "to_wait");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, "to_fire");
      checks++;
      assert (bus.timeout === 1'b1) else begin
         failures++;
         $error("FAIL to_pulse observed=%b expected=1", bus.timeout);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, "to_after");
      cyc(1'b1, 1'b1, 1'b1, 1'b0, "tod_grant");
      for (int i = 0; i < TO - 1; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, "tod_wait");
      cyc(1'b0, 1'b0, 1'b0, 1'b1, "tod_done");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, "tod_after");
`endif

      // Counter wrap after 256 grants from reset, then done in IDLE.
      do_reset();
      for (int n = 0; n < 256; n++) begin
         cyc(n[1], n[0], 1'b1, 1'b0, "wrap_grant");
         cyc(1'b0, 1'b0, 1'b0, 1'b1, "wrap_done");
         cyc(1'b0, 1'b0, 1'b0, 1'b0, "wrap_rel");
      end
      checks++;
      assert (bus.grant_count === '0) else begin
         failures++;
         $error("FAIL wrap_zero observed=%0d expected=0", bus.grant_count);
      end
      cyc(1'b1, 1'b0, 1'b0, 1'b1, "idle_done1");
      cyc(1'b0, 1'b1, 1'b0, 1'b1, "idle_done2");

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0), "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
